// File: rtl/writeback_stage.sv
// Writeback stage: merges single-cycle ALU results with buffered load results
// onto one register-file write port, and keeps a busy scoreboard of
// destinations that have an outstanding load.
//
// Ports
//   clk, reset                     clock; synchronous active-high reset
//   alu_valid/alu_addr/alu_data    ALU result; alu_stall back-pressures it
//   mem_valid/mem_addr/mem_data    load result; accepted when mem_ready
//   issue_valid/issue_addr         load issue, marks destination busy
//   query_addr1/2 -> busy1/2       hazard lookup of current scoreboard state
//   rf_write_enable/addr/data      registered register-file write port
module writeback_stage #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [5:0]  alu_addr,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        mem_valid,
  input  logic [5:0]  mem_addr,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        issue_valid,
  input  logic [5:0]  issue_addr,
  input  logic [5:0]  query_addr1,
  input  logic [5:0]  query_addr2,
  output logic        busy1,
  output logic        busy2,
  output logic        rf_write_enable,
  output logic [5:0]  rf_write_addr,
  output logic [31:0] rf_write_data
);

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  // Load-result buffer storage and control
  logic [AW-1:0]    fifo_addr_q [FIFO_DEPTH];
  logic [AW-1:0]    fifo_addr_d [FIFO_DEPTH];
  logic [DW-1:0]    fifo_data_q [FIFO_DEPTH];
  logic [DW-1:0]    fifo_data_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [NREG-1:0]  busy_q, busy_d;

  logic             rf_we_q, rf_we_d;
  logic [AW-1:0]    rf_addr_q, rf_addr_d;
  logic [DW-1:0]    rf_data_q, rf_data_d;

  logic             full_c;
  logic             empty_c;
  logic             push_c;
  logic             pop_c;
  logic             alu_sel_c;
  logic [AW-1:0]    head_addr_c;
  logic [DW-1:0]    head_data_c;

  assign full_c      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_c     = (count_q == CNT_W'(0));
  assign head_addr_c = fifo_addr_q[rd_ptr_q];
  assign head_data_c = fifo_data_q[rd_ptr_q];

  // A full buffer takes priority so loads cannot starve behind a busy ALU
  assign pop_c     = !empty_c && (full_c || !alu_valid);
  assign alu_sel_c = alu_valid && !full_c;
  assign push_c    = mem_valid && !full_c;

  assign mem_ready = !full_c;
  assign alu_stall = !reset && alu_valid && full_c;

  // Scoreboard lookups see registered state only; addresses >= 32 are never busy
  assign busy1 = !query_addr1[5] && busy_q[query_addr1[4:0]];
  assign busy2 = !query_addr2[5] && busy_q[query_addr2[4:0]];

  assign rf_write_enable = rf_we_q;
  assign rf_write_addr   = rf_addr_q;
  assign rf_write_data   = rf_data_q;

  // Next-state: buffer pointers/count, storage, scoreboard, write port
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    busy_d      = busy_q;
    rf_we_d     = 1'b0;
    rf_addr_d   = rf_addr_q;
    rf_data_d   = rf_data_q;

    if (push_c) begin
      fifo_addr_d[wr_ptr_q] = mem_addr;
      fifo_data_d[wr_ptr_q] = mem_data;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Out-of-range destinations are drained without touching the register file
    if (pop_c) begin
      if (!head_addr_c[5]) begin
        rf_we_d                 = 1'b1;
        rf_addr_d               = head_addr_c;
        rf_data_d               = head_data_c;
        busy_d[head_addr_c[4:0]] = 1'b0;
      end
    end else if (alu_sel_c && !alu_addr[5]) begin
      rf_we_d   = 1'b1;
      rf_addr_d = alu_addr;
      rf_data_d = alu_data;
    end

    // Applied after the clear so a same-cycle issue keeps the bit set
    if (issue_valid && !issue_addr[5]) begin
      busy_d[issue_addr[4:0]] = 1'b1;
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      busy_q    <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  // Buffer payload needs no reset; it is only read when count says valid
  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage with a reference model and a
// scoreboard queue of expected register-file writes.
module tb_writeback_stage;

  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [5:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        mem_valid;
  logic [5:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        issue_valid;
  logic [5:0]  issue_addr;
  logic [5:0]  query_addr1;
  logic [5:0]  query_addr2;
  logic        busy1;
  logic        busy2;
  logic        rf_write_enable;
  logic [5:0]  rf_write_addr;
  logic [31:0] rf_write_data;

  writeback_stage #(.FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .alu_valid       (alu_valid),
    .alu_addr        (alu_addr),
    .alu_data        (alu_data),
    .alu_stall       (alu_stall),
    .mem_valid       (mem_valid),
    .mem_addr        (mem_addr),
    .mem_data        (mem_data),
    .mem_ready       (mem_ready),
    .issue_valid     (issue_valid),
    .issue_addr      (issue_addr),
    .query_addr1     (query_addr1),
    .query_addr2     (query_addr2),
    .busy1           (busy1),
    .busy2           (busy2),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  logic [37:0] model_fifo[$];
  logic [37:0] exp_q[$];
  logic [31:0] busy_m;
  logic [5:0]  last_addr;
  logic [31:0] last_data;
  logic        m_stall;
  logic        m_accept;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs
  task automatic cycle();
    logic        full;
    logic        pop;
    logic        b1;
    logic        b2;
    logic [37:0] head;
    logic [37:0] e;
    #1;
    if (reset) begin
      chk("alu_stall_in_reset", 64'(alu_stall), 64'(0));
      @(posedge clk);
      #1;
      model_fifo.delete();
      exp_q.delete();
      busy_m    = '0;
      last_addr = '0;
      last_data = '0;
      m_stall   = 1'b0;
      m_accept  = 1'b0;
      chk("rf_we_reset", 64'(rf_write_enable), 64'(0));
      chk("rf_addr_reset", 64'(rf_write_addr), 64'(0));
      chk("rf_data_reset", 64'(rf_write_data), 64'(0));
      return;
    end
    full     = (model_fifo.size() == DEPTH);
    m_stall  = alu_valid && full;
    m_accept = mem_valid && !full;
    b1       = query_addr1[5] ? 1'b0 : busy_m[query_addr1[4:0]];
    b2       = query_addr2[5] ? 1'b0 : busy_m[query_addr2[4:0]];
    chk("mem_ready", 64'(mem_ready), 64'(!full));
    chk("alu_stall", 64'(alu_stall), 64'(m_stall));
    chk("busy1", 64'(busy1), 64'(b1));
    chk("busy2", 64'(busy2), 64'(b2));

    pop = (model_fifo.size() != 0) && (full || !alu_valid);
    if (pop) begin
      head = model_fifo.pop_front();
      if (!head[37]) begin
        exp_q.push_back(head);
        busy_m[head[36:32]] = 1'b0;
      end
    end else if (alu_valid && !alu_addr[5]) begin
      exp_q.push_back({alu_addr, alu_data});
    end
    if (m_accept) model_fifo.push_back({mem_addr, mem_data});
    if (issue_valid && !issue_addr[5]) busy_m[issue_addr[4:0]] = 1'b1;

    @(posedge clk);
    #1;
    chk("rf_we", 64'(rf_write_enable), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      last_addr = e[37:32];
      last_data = e[31:0];
      chk("rf_addr", 64'(rf_write_addr), 64'(last_addr));
      chk("rf_data", 64'(rf_write_data), 64'(last_data));
    end else begin
      chk("rf_addr_hold", 64'(rf_write_addr), 64'(last_addr));
      chk("rf_data_hold", 64'(rf_write_data), 64'(last_data));
    end
  endtask

  task automatic idle();
    alu_valid   = 1'b0;
    mem_valid   = 1'b0;
    issue_valid = 1'b0;
  endtask

  initial begin
    logic [5:0] load_addr [3];
    int unsigned li;
    load_addr[0] = 6'd10;
    load_addr[1] = 6'd11;
    load_addr[2] = 6'd12;

    busy_m = '0; last_addr = '0; last_data = '0;
    m_stall = 1'b0; m_accept = 1'b0;
    reset = 1'b1;
    idle();
    alu_addr = '0; alu_data = '0; mem_addr = '0; mem_data = '0;
    issue_addr = '0; query_addr1 = '0; query_addr2 = '0;
    cycle();
    cycle();
    reset = 1'b0;

    // ALU-only write
    alu_valid = 1'b1; alu_addr = 6'd3; alu_data = 32'h1234_5678;
    cycle();
    idle();
    cycle();

    // Load path with scoreboard set and clear
    issue_valid = 1'b1; issue_addr = 6'd5; query_addr1 = 6'd5; query_addr2 = 6'd3;
    cycle();
    idle();
    cycle();
    mem_valid = 1'b1; mem_addr = 6'd5; mem_data = 32'hDEAD_BEEF;
    cycle();
    idle();
    cycle();
    cycle();

    // Contention: ALU valid every cycle while three loads arrive
    for (int k = 0; k < 3; k++) begin
      issue_valid = 1'b1; issue_addr = load_addr[k];
      cycle();
    end
    idle();
    query_addr1 = 6'd10; query_addr2 = 6'd12;
    alu_addr = 6'd20; alu_data = 32'hA000_0000;
    li = 0;
    for (int k = 0; k < 10; k++) begin
      alu_valid = (k < 6);
      mem_valid = (li < 3);
      if (li < 3) begin
        mem_addr = load_addr[li];
        mem_data = 32'hB000_0000 + 32'(li);
      end
      cycle();
      if (alu_valid && !m_stall) alu_data = alu_data + 32'd1;
      if (m_accept) li++;
    end
    idle();

    // Same-cycle issue and pop of register 7
    query_addr1 = 6'd7;
    issue_valid = 1'b1; issue_addr = 6'd7;
    cycle();
    idle();
    mem_valid = 1'b1; mem_addr = 6'd7; mem_data = 32'h0000_0777;
    cycle();
    idle();
    issue_valid = 1'b1; issue_addr = 6'd7;
    cycle();
    idle();
    cycle();

    // Out-of-range destinations are consumed without a write
    alu_valid = 1'b1; alu_addr = 6'd40; alu_data = 32'hFFFF_0000;
    query_addr2 = 6'd40;
    cycle();
    idle();
    mem_valid = 1'b1; mem_addr = 6'd45; mem_data = 32'h4545_4545;
    cycle();
    idle();
    cycle();

    // Reset with the buffer full and an ALU result waiting
    issue_valid = 1'b1; issue_addr = 6'd8;
    cycle();
    idle();
    alu_valid = 1'b1; alu_addr = 6'd1; alu_data = 32'h0000_0001;
    mem_valid = 1'b1; mem_addr = 6'd7; mem_data = 32'h7777_7777;
    cycle();
    alu_data = 32'h0000_0002;
    mem_addr = 6'd8; mem_data = 32'h8888_8888;
    cycle();
    alu_data = 32'h0000_0003;
    mem_addr = 6'd9;
    chk("mem_ready_full", 64'(mem_ready), 64'(0));
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    idle();
    query_addr1 = 6'd7; query_addr2 = 6'd8;
    cycle();
    query_addr1 = 6'd5; query_addr2 = 6'd10;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
